// File: rtl/bytewrite_ram_master_if.sv
// Request/response and RAM-side signal bundle for bytewrite_ram_master.
// The master modport is the block's view; slave is the environment (requester, consumer, RAM).
interface bytewrite_ram_master_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int COL_WIDTH  = 8,
  parameter int NB_COL     = 4
);
  localparam int W = NB_COL * COL_WIDTH;

  logic                  init_start;
  logic                  req_valid;
  logic                  req_ready;
  logic [NB_COL-1:0]     req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [W-1:0]          req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [W-1:0]          rsp_rdata;
  logic                  busy;
  logic                  init_done;
  logic [NB_COL-1:0]     ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [W-1:0]          ram_di;
  logic [W-1:0]          ram_do;

  modport master (
    input  init_start, req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_do,
    output req_ready, rsp_valid, rsp_rdata, busy, init_done, ram_we, ram_addr, ram_di
  );

  modport slave (
    output init_start, req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_do,
    input  req_ready, rsp_valid, rsp_rdata, busy, init_done, ram_we, ram_addr, ram_di
  );
endinterface

// File: rtl/bytewrite_ram_master.sv
// Byte-write RAM front end: clears the RAM after reset or on request, then serves
// byte-masked writes and reads through a 2-entry in-order response FIFO.
module bytewrite_ram_master #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int COL_WIDTH  = 8,
  parameter int NB_COL     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bytewrite_ram_master_if.master   bus
);
  localparam int W = NB_COL * COL_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  inflight_q, inflight_d;
  logic                  oob_q, oob_d;
  logic [W-1:0]          fifo_q [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  accept_s;
  logic                  rd_accept_s;
  logic                  in_range_s;
  logic                  push_s;
  logic                  pop_s;
  logic [W-1:0]          push_data_s;

  // FSM state, sweep counter and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state logic; a restart request always wins over sweep completion
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (bus.init_start) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (bus.init_start) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Request acceptance and combinational RAM drive
  always_comb begin
    in_range_s    = (32'(bus.req_addr) < 32'(SIZE));
    bus.req_ready = (state_q == ST_RUN) && ((count_q + {1'b0, inflight_q}) < 2'd2);
    accept_s      = bus.req_valid && bus.req_ready;
    rd_accept_s   = accept_s && (bus.req_we == '0);
    bus.busy      = (state_q == ST_INIT);
    bus.init_done = init_done_q;
    if (state_q == ST_INIT) begin
      bus.ram_we   = '1;
      bus.ram_addr = cnt_q;
      bus.ram_di   = '0;
    end else begin
      bus.ram_we   = (accept_s && in_range_s) ? bus.req_we : '0;
      bus.ram_addr = bus.req_addr;
      bus.ram_di   = bus.req_wdata;
    end
  end

  // Response FIFO bookkeeping; out-of-range reads return zero instead of RAM data
  always_comb begin
    inflight_d  = rd_accept_s;
    oob_d       = rd_accept_s && !in_range_s;
    push_s      = inflight_q;
    push_data_s = oob_q ? '0 : bus.ram_do;
    pop_s       = (count_q != 2'd0) && bus.rsp_ready;
    rd_ptr_d    = pop_s ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d    = push_s ? ~wr_ptr_q : wr_ptr_q;
    count_d     = count_q + {1'b0, push_s} - {1'b0, pop_s};
    bus.rsp_valid = (count_q != 2'd0);
    bus.rsp_rdata = fifo_q[rd_ptr_q];
  end

  // Response path registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      oob_q      <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      inflight_q <= inflight_d;
      oob_q      <= oob_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push_s) begin
        fifo_q[wr_ptr_q] <= push_data_s;
      end else begin
        fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
      end
    end
  end
endmodule

// File: tb/tb_bytewrite_ram_master.sv
// Directed bench for bytewrite_ram_master with a read-first byte-write RAM model.
module tb_bytewrite_ram_master;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  bytewrite_ram_master_if #(.ADDR_WIDTH(10), .COL_WIDTH(8), .NB_COL(4)) bus ();

  bytewrite_ram_master #(.SIZE(32), .ADDR_WIDTH(10), .COL_WIDTH(8), .NB_COL(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-word RAM indexed by the low address bits, so address 40 aliases word 8
  logic [31:0] mem [32];
  always @(posedge clk) begin
    bus.ram_do <= mem[bus.ram_addr[4:0]];
    for (int b = 0; b < 4; b++) begin
      if (bus.ram_we[b]) mem[bus.ram_addr[4:0]][8*b +: 8] <= bus.ram_di[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic [3:0] we, input logic [9:0] addr, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 4'h0;
    bus.req_addr  = 10'd0;
    bus.req_wdata = 32'h0;
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, "_we"}, {28'd0, bus.ram_we}, 32'hF);
      chk({tag, "_addr"}, {22'd0, bus.ram_addr}, i);
      chk({tag, "_di"}, bus.ram_di, 32'h0);
      chk({tag, "_rdy"}, {31'd0, bus.req_ready}, 32'd0);
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.init_start = 1'b0;
    bus.rsp_ready  = 1'b1;
    idle();
    #10;
    chk("rst_busy", {31'd0, bus.busy}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_init_done", {31'd0, bus.init_done}, 32'd0);
    chk("rst_ram_we", {28'd0, bus.ram_we}, 32'hF);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    sweep("init");
    chk("init_done_pulse", {31'd0, bus.init_done}, 32'd1);
    chk("init_busy_low", {31'd0, bus.busy}, 32'd0);
    chk("init_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("idle_we", {28'd0, bus.ram_we}, 32'h0);
    tick();
    chk("init_done_once", {31'd0, bus.init_done}, 32'd0);

    // Seed word 8 so an aliased access at 40 would be visible
    req(4'hF, 10'd8, 32'h12345678);
    tick();
    // Byte-masked write then immediate read of the same word
    req(4'b0101, 10'd5, 32'hAABBCCDD);
    chk("wr5_we", {28'd0, bus.ram_we}, 32'h5);
    chk("wr5_addr", {22'd0, bus.ram_addr}, 32'd5);
    chk("wr5_di", bus.ram_di, 32'hAABBCCDD);
    tick();
    req(4'h0, 10'd5, 32'h0);
    chk("rd5_we", {28'd0, bus.ram_we}, 32'h0);
    tick();
    idle();
    chk("rd5_lat", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("rd5_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rd5_data", bus.rsp_rdata, 32'h00BB00DD);
    tick();
    chk("rd5_popped", {31'd0, bus.rsp_valid}, 32'd0);

    req(4'hF, 10'd1, 32'h11111111); tick();
    req(4'hF, 10'd2, 32'h22222222); tick();
    req(4'hF, 10'd3, 32'h33333333); tick();
    idle();
    chk("wr_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);

    // Backpressure: only two reads may be outstanding
    bus.rsp_ready = 1'b0;
    req(4'h0, 10'd1, 32'h0);
    chk("bp_rdy0", {31'd0, bus.req_ready}, 32'd1);
    tick();
    req(4'h0, 10'd2, 32'h0);
    chk("bp_rdy1", {31'd0, bus.req_ready}, 32'd1);
    tick();
    req(4'h0, 10'd3, 32'h0);
    chk("bp_rdy2", {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk("bp_rdy3", {31'd0, bus.req_ready}, 32'd0);
    chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("bp_head", bus.rsp_rdata, 32'h11111111);
    tick();
    chk("bp_hold", bus.rsp_rdata, 32'h11111111);
    idle();
    bus.rsp_ready = 1'b1;
    #1;
    tick();
    chk("bp_second", bus.rsp_rdata, 32'h22222222);
    chk("bp_rdy_back", {31'd0, bus.req_ready}, 32'd1);
    tick();
    chk("bp_only_two", {31'd0, bus.rsp_valid}, 32'd0);

    // Streaming with simultaneous push and pop
    req(4'h0, 10'd1, 32'h0); tick();
    req(4'h0, 10'd2, 32'h0); tick();
    req(4'h0, 10'd3, 32'h0);
    chk("st_rdy_full", {31'd0, bus.req_ready}, 32'd0);
    chk("st_head1", bus.rsp_rdata, 32'h11111111);
    tick();
    chk("st_rdy_pp", {31'd0, bus.req_ready}, 32'd1);
    chk("st_head2", bus.rsp_rdata, 32'h22222222);
    tick();
    idle();
    chk("st_gap", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("st_head3", bus.rsp_rdata, 32'h33333333);
    tick();
    chk("st_empty", {31'd0, bus.rsp_valid}, 32'd0);

    // Out-of-range write is suppressed; out-of-range read returns zero
    req(4'hF, 10'd40, 32'hFFFFFFFF);
    chk("oob_we", {28'd0, bus.ram_we}, 32'h0);
    chk("oob_rdy", {31'd0, bus.req_ready}, 32'd1);
    tick();
    req(4'h0, 10'd40, 32'h0); tick();
    idle(); tick();
    chk("oob_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("oob_data", bus.rsp_rdata, 32'h0);
    tick();
    req(4'h0, 10'd8, 32'h0); tick();
    idle(); tick();
    chk("w8_intact", bus.rsp_rdata, 32'h12345678);
    tick();

    // Re-init with a read in flight; requests held during the sweep must wait
    req(4'h0, 10'd5, 32'h0); tick();
    idle();
    bus.init_start = 1'b1;
    #1;
    tick();
    bus.init_start = 1'b0;
    req(4'h0, 10'd5, 32'h0);
    chk("ri_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("ri_data", bus.rsp_rdata, 32'h00BB00DD);
    sweep("reinit");
    chk("ri_done", {31'd0, bus.init_done}, 32'd1);
    chk("ri_no_leak", {31'd0, bus.rsp_valid}, 32'd0);
    chk("ri_accept", {31'd0, bus.req_ready}, 32'd1);
    tick();
    idle(); tick();
    chk("ri_rd_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("ri_cleared", bus.rsp_rdata, 32'h0);
    tick();

    // Reset with a full FIFO
    bus.rsp_ready = 1'b0;
    req(4'h0, 10'd1, 32'h0); tick();
    req(4'h0, 10'd2, 32'h0); tick();
    idle(); tick();
    chk("rr_full", {31'd0, bus.rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_valid0", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rr_busy", {31'd0, bus.busy}, 32'd1);
    chk("rr_we", {28'd0, bus.ram_we}, 32'hF);
    chk("rr_addr", {22'd0, bus.ram_addr}, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    chk("rr_rel_addr", {22'd0, bus.ram_addr}, 32'd0);
    tick();
    chk("rr_addr1", {22'd0, bus.ram_addr}, 32'd1);
    chk("rr_still_empty", {31'd0, bus.rsp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
